inst_queue: RTL and testbench

Instruction queue between the instruction cache and decode. It accepts line-sized fetch responses of 1–8 valid words and buffers up to DEPTH instructions, each tagged with its PC. It hands up to two instructions per cycle to decode in program order. It tracks outstanding cache requests so that responses belonging to a flushed stream are discarded.

---
 rtl/inst_queue_if.sv | 29 ++
 rtl/inst_queue.sv | 149 ++++++++++++++
 tb/tb_inst_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode side bundle of the instruction queue: cache response in, decode slots out.
interface inst_queue_if;
    logic         req_fire;
    logic         in_valid;
    logic [255:0] in_rdata;
    logic [3:0]   in_rnum;
    logic         in_ready;
    logic         flush;
    logic [31:0]  flush_pc;
    logic         out0_valid;
    logic         out1_valid;
    logic [31:0]  out0_inst;
    logic [31:0]  out1_inst;
    logic [31:0]  out0_pc;
    logic [31:0]  out1_pc;
    logic [1:0]   out_ack;

    // Fetch stage and decode drive the queue from this side.
    modport master (
        output req_fire, in_valid, in_rdata, in_rnum, flush, flush_pc, out_ack,
        input  in_ready, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc
    );

    // The queue itself.
    modport slave (
        input  req_fire, in_valid, in_rdata, in_rnum, flush, flush_pc, out_ack,
        output in_ready, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between I-cache and decode: PC-tagged circular buffer,
// up to 8 words in and 2 out per cycle, with stale-response discard after flush.
module inst_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic         clk,
    input  logic         resetn,
    inst_queue_if.slave  q
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned FW    = CW + 2;
    localparam int unsigned LINE  = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic [CW-1:0]   count;
    logic [1:0]      pending;
    logic [1:0]      discard;
    logic [31:0]     fetch_pc;

    logic            accept_c;
    logic [3:0]      enq_n_c;
    logic [1:0]      deq_n_c;
    logic [CW-1:0]   count_next_c;
    logic [1:0]      pending_next_c;
    logic [1:0]      discard_next_c;
    logic [FW-1:0]   fill_c;
    logic            wr_en_c   [LINE];
    logic [AW-1:0]   wr_idx_c  [LINE];
    entry_t          wr_data_c [LINE];

    // Enqueue/dequeue amounts and next-state of the occupancy counters.
    always_comb begin
        accept_c       = q.in_valid && !q.flush && (discard == 2'd0);
        enq_n_c        = 4'd0;
        deq_n_c        = 2'd0;
        pending_next_c = pending;
        discard_next_c = discard;

        if (accept_c) begin
            enq_n_c = (q.in_rnum > 4'd8) ? 4'd8 : q.in_rnum;
        end
        if (!q.flush) begin
            deq_n_c = q.out_ack;
        end
        count_next_c = count + CW'(enq_n_c) - CW'(deq_n_c);

        // A stale data_ok after reset finds pending at 0; hold it there.
        if (q.req_fire && !q.in_valid) begin
            pending_next_c = pending + 2'd1;
        end else if (!q.req_fire && q.in_valid && (pending != 2'd0)) begin
            pending_next_c = pending - 2'd1;
        end

        // Responses still owed to the old stream; the flush-cycle response is already gone.
        if (q.flush) begin
            discard_next_c = (q.in_valid && (pending != 2'd0)) ? pending - 2'd1 : pending;
        end else if (q.in_valid && (discard != 2'd0)) begin
            discard_next_c = discard - 2'd1;
        end
    end

    // Map the valid top words of the line onto consecutive queue slots.
    always_comb begin
        for (int k = 0; k < int'(LINE); k++) begin
            wr_en_c[k]        = (4'(k) < enq_n_c);
            wr_idx_c[k]       = wptr + AW'(k);
            wr_data_c[k].pc   = fetch_pc + 32'(4 * k);
            wr_data_c[k].inst = q.in_rdata[32 * ((k + int'(LINE) - int'(enq_n_c)) % int'(LINE)) +: 32];
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LINE); k++) begin
            if (wr_en_c[k]) begin
                mem[wr_idx_c[k]] <= wr_data_c[k];
            end
        end
    end

    // Pointers, occupancy, outstanding-request tracking and fetch PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            pending  <= 2'd0;
            discard  <= 2'd0;
            fetch_pc <= RESET_PC;
        end else begin
            pending <= pending_next_c;
            discard <= discard_next_c;
            if (q.flush) begin
                rptr     <= '0;
                wptr     <= '0;
                count    <= '0;
                fetch_pc <= q.flush_pc;
            end else begin
                rptr  <= rptr + AW'(deq_n_c);
                wptr  <= wptr + AW'(enq_n_c);
                count <= count_next_c;
                if (accept_c) begin
                    fetch_pc <= fetch_pc + (32'(enq_n_c) << 2);
                end
            end
        end
    end

    // Issue a request only when every outstanding line is guaranteed to fit.
    always_comb begin
        fill_c     = FW'(count) + FW'({pending, 3'b000});
        q.in_ready = q.flush || (fill_c <= FW'(DEPTH - LINE));
    end

    // Decode slots read straight from the two oldest entries.
    always_comb begin
        q.out0_valid = (count != '0);
        q.out1_valid = (count >= CW'(2));
        q.out0_pc    = mem[rptr].pc;
        q.out0_inst  = mem[rptr].inst;
        q.out1_pc    = mem[rptr + AW'(1)].pc;
        q.out1_inst  = mem[rptr + AW'(1)].inst;
    end

`ifndef SYNTHESIS
    // Protocol checks on the fetch and decode sides.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(q.in_valid && (q.in_rnum > 4'd8)))
                else $error("inst_queue: in_rnum %0d above line size", q.in_rnum);
            assert (q.flush || !((q.out_ack > 2'd2) || (CW'(q.out_ack) > count)))
                else $error("inst_queue: out_ack %0d exceeds valid slots", q.out_ack);
            assert (!(q.req_fire && !q.in_valid && (pending >= 2'd2)))
                else $error("inst_queue: more than two outstanding requests");
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected {pc,inst} pushed on response, popped on ack.
module tb_inst_queue;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        resetn;
    int          n_cmp;
    int          n_err;
    logic [31:0] m_pc;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_v;
    logic [31:0] mon_pc;
    logic [31:0] mon_inst;

    inst_queue_if qif ();

    inst_queue #(.DEPTH(16), .RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every acked slot must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && qif.flush === 1'b0) begin
            for (int s = 0; s < int'(qif.out_ack); s++) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow slot%0d acked with nothing expected", s);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_v    = (s == 0) ? qif.out0_valid : qif.out1_valid;
                    mon_pc   = (s == 0) ? qif.out0_pc    : qif.out1_pc;
                    mon_inst = (s == 0) ? qif.out0_inst  : qif.out1_inst;
                    if (mon_v !== 1'b1 || mon_pc !== mon_e.pc || mon_inst !== mon_e.inst) begin
                        n_err++;
                        $display("FAIL sb_slot%0d got v=%0b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                 s, mon_v, mon_pc, mon_inst, mon_e.pc, mon_e.inst);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        qif.req_fire = 1'b0;
        qif.in_valid = 1'b0;
        qif.in_rdata = '0;
        qif.in_rnum  = 4'd0;
        qif.flush    = 1'b0;
        qif.flush_pc = '0;
        qif.out_ack  = 2'd0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        exp_q.delete();
        m_pc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic do_req();
        qif.req_fire = 1'b1;
        tick();
        qif.req_fire = 1'b0;
    endtask

    // Line word k = base+k; the top n words are valid. drop=1 means the queue must discard it.
    task automatic do_resp(input int n, input logic [31:0] base, input logic [1:0] ack, input bit drop);
        exp_t e;
        for (int k = 0; k < 8; k++) qif.in_rdata[32*k +: 32] = base + 32'(k);
        qif.in_rnum  = 4'(n);
        qif.in_valid = 1'b1;
        qif.out_ack  = ack;
        if (!drop) begin
            for (int k = 0; k < n; k++) begin
                e.pc   = m_pc + 32'(4 * k);
                e.inst = base + 32'(8 - n + k);
                exp_q.push_back(e);
            end
            m_pc = m_pc + 32'(4 * n);
        end
        tick();
        qif.in_valid = 1'b0;
        qif.out_ack  = 2'd0;
    endtask

    task automatic drain(input int cycles, input logic [1:0] ack);
        qif.out_ack = ack;
        repeat (cycles) tick();
        qif.out_ack = 2'd0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (qif.out0_valid !== 1'b0) begin n_err++; $display("FAIL reset_out0_valid got %b need 0", qif.out0_valid); end
        n_cmp++; if (qif.out1_valid !== 1'b0) begin n_err++; $display("FAIL reset_out1_valid got %b need 0", qif.out1_valid); end
        n_cmp++; if (qif.in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got %b need 1", qif.in_ready); end
    endtask

    task automatic test_full_line();
        do_reset();
        do_req();
        do_resp(8, 32'h100, 2'd0, 1'b0);
        n_cmp++; if (qif.out0_pc !== 32'hbfc00000 || qif.out0_inst !== 32'h100)
            begin n_err++; $display("FAIL line_out0 got pc=%h inst=%h need bfc00000/100", qif.out0_pc, qif.out0_inst); end
        n_cmp++; if (qif.out1_pc !== 32'hbfc00004 || qif.out1_inst !== 32'h101)
            begin n_err++; $display("FAIL line_out1 got pc=%h inst=%h need bfc00004/101", qif.out1_pc, qif.out1_inst); end
        drain(4, 2'd2);
        n_cmp++; if (qif.out0_valid !== 1'b0) begin n_err++; $display("FAIL line_drained got v=%b need 0", qif.out0_valid); end
    endtask

    task automatic test_partial();
        do_reset();
        do_req();
        do_resp(3, 32'h5, 2'd0, 1'b0);
        n_cmp++; if (qif.out0_pc !== 32'hbfc00000 || qif.out0_inst !== 32'hA)
            begin n_err++; $display("FAIL part_head got pc=%h inst=%h need bfc00000/a", qif.out0_pc, qif.out0_inst); end
        drain(1, 2'd2);
        n_cmp++; if (qif.out0_pc !== 32'hbfc00008 || qif.out1_valid !== 1'b0)
            begin n_err++; $display("FAIL part_tail got pc=%h v1=%b need bfc00008/0", qif.out0_pc, qif.out1_valid); end
        drain(1, 2'd1);
        do_req();
        do_resp(1, 32'hDEAD - 32'd7, 2'd0, 1'b0);
        n_cmp++; if (qif.out0_valid !== 1'b1 || qif.out1_valid !== 1'b0)
            begin n_err++; $display("FAIL single_valid got v0=%b v1=%b need 1/0", qif.out0_valid, qif.out1_valid); end
        n_cmp++; if (qif.out0_pc !== 32'hbfc0000c || qif.out0_inst !== 32'hDEAD)
            begin n_err++; $display("FAIL single_entry got pc=%h inst=%h need bfc0000c/dead", qif.out0_pc, qif.out0_inst); end
        drain(1, 2'd1);
    endtask

    task automatic test_flush();
        do_reset();
        do_req();
        do_req();
        n_cmp++; if (qif.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_ready got %b need 0", qif.in_ready); end
        qif.flush    = 1'b1;
        qif.flush_pc = 32'h80001000;
        qif.in_valid = 1'b1;
        qif.in_rnum  = 4'd8;
        qif.in_rdata = {8{32'hBADBAD00}};
        #1;
        n_cmp++; if (qif.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_cycle_ready got %b need 1", qif.in_ready); end
        tick();
        idle_inputs();
        exp_q.delete();
        m_pc = 32'h80001000;
        n_cmp++; if (qif.out0_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got v=%b need 0", qif.out0_valid); end
        do_resp(8, 32'hBAD0, 2'd0, 1'b1);
        n_cmp++; if (qif.out0_valid !== 1'b0) begin n_err++; $display("FAIL stale_dropped got v=%b need 0", qif.out0_valid); end
        do_req();
        do_resp(2, 32'h20, 2'd0, 1'b0);
        n_cmp++; if (qif.out0_pc !== 32'h80001000 || qif.out0_inst !== 32'h26)
            begin n_err++; $display("FAIL new_stream got pc=%h inst=%h need 80001000/26", qif.out0_pc, qif.out0_inst); end
        // Flush with entries queued and an ack in the same cycle: ack ignored, queue empties.
        qif.flush    = 1'b1;
        qif.flush_pc = 32'h00001000;
        qif.out_ack  = 2'd2;
        tick();
        idle_inputs();
        exp_q.delete();
        m_pc = 32'h00001000;
        n_cmp++; if (qif.out0_valid !== 1'b0 || qif.in_ready !== 1'b1)
            begin n_err++; $display("FAIL flush_clear got v=%b rdy=%b need 0/1", qif.out0_valid, qif.in_ready); end
        do_req();
        do_resp(1, 32'h40, 2'd0, 1'b0);
        drain(1, 2'd1);
    endtask

    task automatic test_wrap();
        do_reset();
        do_req();
        do_resp(8, 32'h200, 2'd0, 1'b0);
        do_req();
        do_resp(4, 32'h300, 2'd0, 1'b0);
        n_cmp++; if (qif.in_ready !== 1'b0) begin n_err++; $display("FAIL cnt12_ready got %b need 0", qif.in_ready); end
        drain(6, 2'd2);
        n_cmp++; if (qif.out0_valid !== 1'b0 || qif.in_ready !== 1'b1)
            begin n_err++; $display("FAIL wrap_empty got v=%b rdy=%b need 0/1", qif.out0_valid, qif.in_ready); end
        do_req();
        do_resp(8, 32'h400, 2'd0, 1'b0);
        n_cmp++; if (qif.in_ready !== 1'b1) begin n_err++; $display("FAIL cnt8_ready got %b need 1", qif.in_ready); end
        do_req();
        n_cmp++; if (qif.in_ready !== 1'b0) begin n_err++; $display("FAIL cnt8_pend1_ready got %b need 0", qif.in_ready); end
        do_resp(8, 32'h500, 2'd2, 1'b0);
        n_cmp++; if (qif.out0_inst !== 32'h402 || qif.in_ready !== 1'b0)
            begin n_err++; $display("FAIL cnt14 got inst=%h rdy=%b need 402/0", qif.out0_inst, qif.in_ready); end
        drain(7, 2'd2);
        n_cmp++; if (qif.out0_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drained got v=%b need 0", qif.out0_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_req();
        do_resp(8, 32'h600, 2'd0, 1'b0);
        drain(1, 2'd2);
        drain(1, 2'd1);
        do_req();
        n_cmp++; if (qif.out1_valid !== 1'b1) begin n_err++; $display("FAIL mid_count5 got v1=%b need 1", qif.out1_valid); end
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (qif.out0_valid !== 1'b0 || qif.out1_valid !== 1'b0 || qif.in_ready !== 1'b1)
            begin n_err++; $display("FAIL async_reset got v0=%b v1=%b rdy=%b need 0/0/1",
                                    qif.out0_valid, qif.out1_valid, qif.in_ready); end
        exp_q.delete();
        m_pc = RST_PC;
        tick();
        resetn = 1'b1;
        tick();
        do_resp(1, 32'h700 - 32'd7, 2'd0, 1'b0);
        n_cmp++; if (qif.out0_pc !== 32'hbfc00000 || qif.out0_inst !== 32'h700)
            begin n_err++; $display("FAIL post_reset got pc=%h inst=%h need bfc00000/700", qif.out0_pc, qif.out0_inst); end
        n_cmp++; if (qif.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b need 1", qif.in_ready); end
        drain(1, 2'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        m_pc   = RST_PC;
        idle_inputs();
        test_reset();
        test_full_line();
        test_partial();
        test_flush();
        test_wrap();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got %0d entries need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
